// File: rtl/user_dma_wr_streamer_if.sv
// Handshake bundle between a user-stream write-DMA source and its host/user neighbours.
// slave = streamer side, master = the logic driving starts, user words and DMA strobes.
interface user_dma_wr_streamer_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int DMA_LEN        = 5,
   parameter int XFER_LEN_WIDTH = 32
);
   logic                      i_start;
   logic [ADDR_WIDTH-1:0]     i_host_addr;
   logic [XFER_LEN_WIDTH-1:0] i_xfer_len;
   logic                      o_busy;
   logic                      o_xfer_done;
   logic                      o_err;
   logic                      i_user_valid;
   logic [DATA_WIDTH-1:0]     i_user_data;
   logic                      o_user_ready;
   logic                      o_dma_data_avail;
   logic [ADDR_WIDTH-1:0]     o_dma_wr_addr;
   logic [DMA_LEN-1:0]        o_dma_len;
   logic                      i_dma_data_rd;
   logic [DATA_WIDTH-1:0]     o_dma_data;
   logic                      i_dma_done;

   modport slave (
      input  i_start, i_host_addr, i_xfer_len, i_user_valid, i_user_data,
             i_dma_data_rd, i_dma_done,
      output o_busy, o_xfer_done, o_err, o_user_ready, o_dma_data_avail,
             o_dma_wr_addr, o_dma_len, o_dma_data
   );

   modport master (
      output i_start, i_host_addr, i_xfer_len, i_user_valid, i_user_data,
             i_dma_data_rd, i_dma_done,
      input  o_busy, o_xfer_done, o_err, o_user_ready, o_dma_data_avail,
             o_dma_wr_addr, o_dma_len, o_dma_data
   );
endinterface

// File: rtl/user_dma_wr_streamer.sv
// Write-DMA source: buffers user words in a FWFT FIFO and slices a host transfer into bursts.
// data_avail rises 1 cycle after the FIFO holds a full burst; user side stalls only when FIFO full.
module user_dma_wr_streamer #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int DMA_LEN        = 5,
   parameter int BURST_WORDS    = 16,
   parameter int FIFO_DEPTH     = 64,
   parameter int XFER_LEN_WIDTH = 32
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   user_dma_wr_streamer_if.slave bus
);
   localparam int BPW_SH = $clog2(DATA_WIDTH / 8);
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int CW     = PW + 1;

   typedef enum logic [1:0] {IDLE, FILL, AVAIL, XDONE} state_t;

   state_t                    state_q, state_d;
   logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]             count_q, count_d;
   logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
   logic [XFER_LEN_WIDTH-1:0] rem_q, rem_d;
   logic [DMA_LEN:0]          popped_q, popped_d;
   logic                      err_q, err_d;

   logic                      full, empty, push, pop, enough, avail;
   logic [DMA_LEN-1:0]        burst_len;
   logic [DMA_LEN:0]          popped_now;
   logic [XFER_LEN_WIDTH-1:0] rem_after;

   assign full       = (count_q == CW'(FIFO_DEPTH));
   assign empty      = (count_q == '0);
   assign push       = bus.i_user_valid & ~full;
   assign pop        = bus.i_dma_data_rd & ~empty;
   assign burst_len  = (rem_q >= XFER_LEN_WIDTH'(BURST_WORDS)) ? DMA_LEN'(BURST_WORDS)
                                                              : rem_q[DMA_LEN-1:0];
   assign enough     = (32'(count_q) >= 32'(burst_len));
   assign popped_now = popped_q + {{DMA_LEN{1'b0}}, pop};
   assign rem_after  = rem_q - XFER_LEN_WIDTH'(burst_len);

   // FIFO storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr_q] <= bus.i_user_data;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         cur_addr_q <= '0;
         rem_q      <= '0;
         popped_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         cur_addr_q <= cur_addr_d;
         rem_q      <= rem_d;
         popped_q   <= popped_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.i_start) state_d = (bus.i_xfer_len == '0) ? XDONE : FILL;
         FILL:  if (enough) state_d = AVAIL;
         AVAIL: if (bus.i_dma_done) state_d = (rem_after == '0) ? XDONE : FILL;
         XDONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Burst bookkeeping; a pop in the done cycle still counts toward the length check.
   always_comb begin
      cur_addr_d = cur_addr_q;
      rem_d      = rem_q;
      popped_d   = popped_q;
      err_d      = err_q;
      if (state_q == IDLE && bus.i_start) begin
         cur_addr_d = bus.i_host_addr;
         rem_d      = bus.i_xfer_len >> BPW_SH;
         popped_d   = '0;
         err_d      = 1'b0;
      end
      if (state_q == AVAIL) begin
         if (pop) popped_d = popped_now;
         if (bus.i_dma_data_rd && empty) err_d = 1'b1;
         if (bus.i_dma_done) begin
            cur_addr_d = cur_addr_q + (ADDR_WIDTH'(burst_len) << BPW_SH);
            rem_d      = rem_after;
            popped_d   = '0;
            if (popped_now != {1'b0, burst_len}) err_d = 1'b1;
         end
      end
   end

   always_comb begin
      avail                = (state_q == AVAIL);
      bus.o_busy           = (state_q == FILL) || (state_q == AVAIL);
      bus.o_xfer_done      = (state_q == XDONE);
      bus.o_dma_data_avail = avail;
      bus.o_dma_wr_addr    = avail ? cur_addr_q : '0;
      bus.o_dma_len        = avail ? burst_len : '0;
   end

   assign bus.o_err        = err_q;
   assign bus.o_user_ready = ~full;
   assign bus.o_dma_data   = empty ? '0 : mem[rd_ptr_q];
endmodule

// File: tb/tb_user_dma_wr_streamer.sv
// Bench for user_dma_wr_streamer: transfer table, hand-written corner sequences and random
// transfers, checked against a word queue and a burst list derived from the transfer rules.
module tb_user_dma_wr_streamer;
   localparam int DEPTH = 64;

   logic i_clk = 1'b0;
   logic i_rst_n;
   always #5 i_clk = ~i_clk;

   user_dma_wr_streamer_if bus ();
   user_dma_wr_streamer dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

   typedef struct {
      logic [31:0] addr;
      logic [31:0] len;
      int          pv;
      int          rv;
      int          exp_bursts;
      int          exp_first_len;
      logic [31:0] exp_last_addr;
   } vec_t;

   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] mq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   // One clock: drive, check FIFO-facing outputs against the word queue, advance.
   task automatic cyc(input bit v, input bit rd, input bit dn);
      logic [63:0] d;
      bit          do_push, do_pop;
      d = {$urandom, $urandom};
      bus.i_user_valid  = v;
      bus.i_user_data   = d;
      bus.i_dma_data_rd = rd;
      bus.i_dma_done    = dn;
      do_push = v && (mq.size() < DEPTH);
      do_pop  = rd && (mq.size() != 0);
      chk("user_ready", bus.o_user_ready, (mq.size() < DEPTH));
      if (do_pop) begin
         chk("dma_data", bus.o_dma_data, mq[0]);
         void'(mq.pop_front());
      end
      if (do_push) mq.push_back(d);
      tick();
      bus.i_user_valid  = 1'b0;
      bus.i_dma_data_rd = 1'b0;
      bus.i_dma_done    = 1'b0;
      bus.i_start       = 1'b0;
   endtask

   task automatic start_xfer(input logic [31:0] a, input logic [31:0] l);
      bus.i_start     = 1'b1;
      bus.i_host_addr = a;
      bus.i_xfer_len  = l;
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_xfer(input logic [31:0] a, input logic [31:0] l, input int push_words,
                           input int pv, input int rv, output int nb, output int first_len,
                           output logic [31:0] last_addr);
      logic [31:0] ea[$];
      int          el[$];
      logic [31:0] ca;
      int          r, bl, pushed, reads, cycles;
      bit          fin, in_burst, just_done, v, rd, dn;
      ca = a;
      r  = int'(l / 8);
      while (r > 0) begin
         bl = (r < 16) ? r : 16;
         ea.push_back(ca);
         el.push_back(bl);
         ca = ca + 32'(bl * 8);
         r  = r - bl;
      end
      nb = 0; first_len = 0; last_addr = '0;
      pushed = 0; reads = 0; cycles = 0;
      fin = 0; in_burst = 0; just_done = 0;
      start_xfer(a, l);
      while (!fin && cycles < 4000) begin
         cycles++;
         if (just_done) chk("avail_gap", bus.o_dma_data_avail, 1'b0);
         just_done = 0;
         if (bus.o_xfer_done) begin
            chk("bursts_left", ea.size(), 0);
            chk("busy_at_done", bus.o_busy, 1'b0);
            chk("avail_at_done", bus.o_dma_data_avail, 1'b0);
            chk("err_clean", bus.o_err, 1'b0);
            fin = 1;
         end else begin
            chk("busy", bus.o_busy, 1'b1);
         end
         if (!fin && bus.o_dma_data_avail) begin
            if (ea.size() == 0) begin
               chk("extra_burst", bus.o_dma_data_avail, 1'b0);
               fin = 1;
            end else begin
               chk("wr_addr", bus.o_dma_wr_addr, ea[0]);
               chk("dma_len", bus.o_dma_len, el[0]);
               if (!in_burst) begin
                  in_burst = 1;
                  reads    = 0;
                  nb++;
                  if (nb == 1) first_len = int'(bus.o_dma_len);
                  last_addr = bus.o_dma_wr_addr;
               end
            end
         end else if (in_burst) begin
            chk("avail_dropped", bus.o_dma_data_avail, 1'b1);
            in_burst = 0;
         end
         if (fin) break;
         v  = (pushed < push_words) && ($urandom_range(99) < pv);
         rd = 0;
         dn = 0;
         if (in_burst) begin
            if (reads < el[0] && $urandom_range(99) < rv) begin
               rd = 1;
               if (reads == el[0] - 1 && $urandom_range(1) == 1) dn = 1;
            end else if (reads == el[0]) begin
               dn = 1;
            end
         end
         if (v && mq.size() < DEPTH) pushed++;
         if (rd) reads++;
         if (dn) begin
            void'(ea.pop_front());
            void'(el.pop_front());
            in_burst  = 0;
            just_done = 1;
         end
         cyc(v, rd, dn);
      end
      chk("xfer_done_seen", fin, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[6];
      int          nb, fl;
      logic [31:0] la, ra, rl;

      vt[0] = '{32'h0000_1000, 32'd256, 100, 100, 2, 16, 32'h0000_1080};
      vt[1] = '{32'h0000_2000, 32'd40,   60,  50, 1,  5, 32'h0000_2000};
      vt[2] = '{32'hFFFF_FFC0, 32'd256,  80,  70, 2, 16, 32'h0000_0040};
      vt[3] = '{32'h0000_0100, 32'd136,  50,  90, 2, 16, 32'h0000_0180};
      vt[4] = '{32'h0000_0000, 32'd8,   100, 100, 1,  1, 32'h0000_0000};
      vt[5] = '{32'h0000_4000, 32'd0,   100, 100, 0,  0, 32'h0000_0000};

      i_rst_n = 1'b0;
      bus.i_start = 1'b0; bus.i_host_addr = '0; bus.i_xfer_len = '0;
      bus.i_user_valid = 1'b0; bus.i_user_data = '0;
      bus.i_dma_data_rd = 1'b0; bus.i_dma_done = 1'b0;
      #2;
      chk("rst_busy", bus.o_busy, 1'b0);
      chk("rst_done", bus.o_xfer_done, 1'b0);
      chk("rst_err", bus.o_err, 1'b0);
      chk("rst_avail", bus.o_dma_data_avail, 1'b0);
      chk("rst_ready", bus.o_user_ready, 1'b1);
      chk("rst_data", bus.o_dma_data, 64'h0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run_xfer(vt[i].addr, vt[i].len, int'(vt[i].len / 8), vt[i].pv, vt[i].rv, nb, fl, la);
         chk("tbl_bursts", nb, vt[i].exp_bursts);
         chk("tbl_first_len", fl, vt[i].exp_first_len);
         chk("tbl_last_addr", la, vt[i].exp_last_addr);
      end

      // data_avail must wait for the fifth word, then rise one cycle later
      start_xfer(32'h0000_2000, 32'd40);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         chk("avail_short", bus.o_dma_data_avail, 1'b0);
      end
      cyc(1'b1, 1'b0, 1'b0);
      chk("avail_early", bus.o_dma_data_avail, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("avail_latency", bus.o_dma_data_avail, 1'b1);
      chk("t2_len", bus.o_dma_len, 5'd5);
      chk("t2_addr", bus.o_dma_wr_addr, 32'h0000_2000);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("t2_xfer_done", bus.o_xfer_done, 1'b1);
      chk("t2_avail_off", bus.o_dma_data_avail, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("t2_done_pulse", bus.o_xfer_done, 1'b0);

      // fill to capacity while idle, then drain through a long transfer
      for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 1'b0, 1'b0);
      chk("full_ready", bus.o_user_ready, 1'b0);
      run_xfer(32'h0000_3000, 32'd1024, DEPTH, 70, 80, nb, fl, la);
      chk("t4_bursts", nb, 8);

      // short burst flags error
      start_xfer(32'h0000_5000, 32'd128);
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("t5_avail", bus.o_dma_data_avail, 1'b1);
      for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("t5_done", bus.o_xfer_done, 1'b1);
      chk("err_short", bus.o_err, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("err_held", bus.o_err, 1'b1);

      // start clears error; the leftover word heads the next burst; read on empty flags error
      start_xfer(32'h0000_5800, 32'd64);
      chk("err_clear", bus.o_err, 1'b0);
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("t5b_avail", bus.o_dma_data_avail, 1'b1);
      chk("t5b_len", bus.o_dma_len, 5'd8);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0);
      chk("t5b_no_err_yet", bus.o_err, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("err_underflow", bus.o_err, 1'b1);
      chk("t5b_still_avail", bus.o_dma_data_avail, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      chk("t5b_done", bus.o_xfer_done, 1'b1);
      chk("err_sticky", bus.o_err, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);

      // zero-length transfer completes at once
      start_xfer(32'h0000_6000, 32'd0);
      chk("zl_done", bus.o_xfer_done, 1'b1);
      chk("zl_busy", bus.o_busy, 1'b0);
      chk("zl_avail", bus.o_dma_data_avail, 1'b0);
      chk("zl_err_clear", bus.o_err, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("zl_done_pulse", bus.o_xfer_done, 1'b0);

      // reset while a burst is presented
      start_xfer(32'h0000_7000, 32'd128);
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("t6_avail", bus.o_dma_data_avail, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
      i_rst_n = 1'b0;
      #1;
      chk("mrst_avail", bus.o_dma_data_avail, 1'b0);
      chk("mrst_addr", bus.o_dma_wr_addr, 32'h0);
      chk("mrst_len", bus.o_dma_len, 5'd0);
      chk("mrst_busy", bus.o_busy, 1'b0);
      chk("mrst_done", bus.o_xfer_done, 1'b0);
      chk("mrst_data", bus.o_dma_data, 64'h0);
      chk("mrst_ready", bus.o_user_ready, 1'b1);
      mq.delete();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      chk("post_rst_done", bus.o_xfer_done, 1'b0);
      chk("post_rst_err", bus.o_err, 1'b0);
      run_xfer(32'h0000_8000, 32'd64, 8, 90, 90, nb, fl, la);
      chk("post_rst_bursts", nb, 1);

      for (int i = 0; i < 15; i++) begin
         ra = $urandom & 32'hFFFF_FFF8;
         rl = 32'(8 * $urandom_range(48, 1));
         run_xfer(ra, rl, int'(rl / 8), $urandom_range(100, 30), $urandom_range(100, 30),
                  nb, fl, la);
         chk("rand_bursts", nb, (int'(rl / 8) + 15) / 16);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
